// File: rtl/desip_axil_regbank.sv
// AXI4-Lite slave register bank for the DES IP: NUM_REGS registers, byte strobes, RO status mapping, write pulses.
// Define DESIP_AXIL_IRQ_EN to add the IRQ_STATUS/IRQ_ENABLE registers and the irq_event/irq ports.
module desip_axil_regbank #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 6,
  parameter int          NUM_REGS           = 8,
  parameter logic [15:0] RO_MASK            = 16'h0080
) (
  input  logic                               ACLK,
  input  logic                               ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]      S_AXI_AWADDR,
  input  logic [2:0]                         S_AXI_AWPROT,
  input  logic                               S_AXI_AWVALID,
  output logic                               S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]      S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]    S_AXI_WSTRB,
  input  logic                               S_AXI_WVALID,
  output logic                               S_AXI_WREADY,
  output logic [1:0]                         S_AXI_BRESP,
  output logic                               S_AXI_BVALID,
  input  logic                               S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]      S_AXI_ARADDR,
  input  logic [2:0]                         S_AXI_ARPROT,
  input  logic                               S_AXI_ARVALID,
  output logic                               S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]      S_AXI_RDATA,
  output logic [1:0]                         S_AXI_RRESP,
  output logic                               S_AXI_RVALID,
  input  logic                               S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_in,
  output logic [NUM_REGS-1:0]                wr_pulse
`ifdef DESIP_AXIL_IRQ_EN
  ,
  input  logic                               irq_event,
  output logic                               irq
`endif
);

  localparam int DW       = C_S_AXI_DATA_WIDTH;
  localparam int STRB_W   = DW / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = C_S_AXI_ADDR_WIDTH - ADDR_LSB;
  localparam logic [NUM_REGS-1:0] RO = RO_MASK[NUM_REGS-1:0];
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic              aresetn_q;
  logic              aw_full, w_full;
  logic [IDX_W-1:0]  aw_idx;
  logic [DW-1:0]     w_data;
  logic [STRB_W-1:0] w_strb;
  logic [DW-1:0]     regs [NUM_REGS];

  logic [IDX_W-1:0]    rd_idx;
  logic [NUM_REGS-1:0] wr_sel, rd_sel;
  logic                aw_hs, w_hs, ar_hs, commit, wr_ok, rd_ok;
  logic [DW-1:0]       rd_data;

  assign S_AXI_AWREADY = aresetn_q & ~aw_full;
  assign S_AXI_WREADY  = aresetn_q & ~w_full;
  assign S_AXI_ARREADY = aresetn_q & ~S_AXI_RVALID;

  assign aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
  assign commit = aw_full & w_full & ~S_AXI_BVALID;
  assign rd_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];

  always_comb begin
    wr_sel = '0;
    rd_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_sel[i] = (aw_idx == IDX_W'(i));
      rd_sel[i] = (rd_idx == IDX_W'(i));
    end
  end

  assign wr_pulse = commit ? (wr_sel & ~RO) : '0;

  // READY only comes up one cycle after the reset release is seen
  always_ff @(posedge ACLK) begin
    if (!ARESETN) aresetn_q <= 1'b0;
    else          aresetn_q <= 1'b1;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      aw_idx  <= '0;
      w_data  <= '0;
      w_strb  <= '0;
    end else begin
      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_idx  <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
      end else if (commit) begin
        aw_full <= 1'b0;
      end
      if (w_hs) begin
        w_full <= 1'b1;
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end else if (commit) begin
        w_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (commit) begin
      for (int i = 0; i < NUM_REGS; i++)
        if (wr_sel[i] && !RO[i])
          for (int b = 0; b < STRB_W; b++)
            if (w_strb[b]) regs[i][8*b +: 8] <= w_data[8*b +: 8];
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign reg_out[g*DW +: DW] = RO[g] ? '0 : regs[g];
  end

`ifdef DESIP_AXIL_IRQ_EN
  logic irq_status, irq_enable;
  logic wr_stat_sel, wr_en_sel, rd_stat_sel, rd_en_sel;

  assign wr_stat_sel = (aw_idx == IDX_W'(NUM_REGS));
  assign wr_en_sel   = (aw_idx == IDX_W'(NUM_REGS + 1));
  assign rd_stat_sel = (rd_idx == IDX_W'(NUM_REGS));
  assign rd_en_sel   = (rd_idx == IDX_W'(NUM_REGS + 1));
  assign wr_ok       = |(wr_sel & ~RO) | wr_stat_sel | wr_en_sel;

  // A new event wins over a write-1-to-clear in the same cycle
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      irq_status <= 1'b0;
      irq_enable <= 1'b0;
      irq        <= 1'b0;
    end else begin
      if (irq_event)
        irq_status <= 1'b1;
      else if (commit && wr_stat_sel && w_strb[0] && w_data[0])
        irq_status <= 1'b0;
      if (commit && wr_en_sel && w_strb[0])
        irq_enable <= w_data[0];
      irq <= irq_status & irq_enable;
    end
  end
`else
  assign wr_ok = |(wr_sel & ~RO);
`endif

  always_comb begin
    rd_data = '0;
    rd_ok   = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_sel[i]) begin
        rd_ok   = 1'b1;
        rd_data = RO[i] ? reg_in[i*DW +: DW] : regs[i];
      end
    end
`ifdef DESIP_AXIL_IRQ_EN
    if (rd_stat_sel) begin
      rd_ok   = 1'b1;
      rd_data = DW'(irq_status);
    end
    if (rd_en_sel) begin
      rd_ok   = 1'b1;
      rd_data = DW'(irq_enable);
    end
`endif
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= RESP_OKAY;
    end else if (commit) begin
      S_AXI_BVALID <= 1'b1;
      S_AXI_BRESP  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (S_AXI_BVALID && S_AXI_BREADY) begin
      S_AXI_BVALID <= 1'b0;
    end
  end

  // Read data is captured at AR acceptance, so a same-edge write is not visible
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA  <= '0;
      S_AXI_RRESP  <= RESP_OKAY;
    end else if (ar_hs) begin
      S_AXI_RVALID <= 1'b1;
      S_AXI_RDATA  <= rd_data;
      S_AXI_RRESP  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (S_AXI_RVALID && S_AXI_RREADY) begin
      S_AXI_RVALID <= 1'b0;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[ADDR_LSB-1:0],
                       S_AXI_ARADDR[ADDR_LSB-1:0], reg_in};

endmodule

// File: tb/tb_desip_axil_regbank.sv
// Directed self-checking bench for desip_axil_regbank (default parameters).
// Covers the IRQ registers as well when DESIP_AXIL_IRQ_EN is defined.
module tb_desip_axil_regbank;

  localparam int DW = 32;
  localparam int AW = 6;
  localparam int NR = 8;

  logic            ACLK = 1'b0;
  logic            ARESETN;
  logic [AW-1:0]   S_AXI_AWADDR, S_AXI_ARADDR;
  logic [2:0]      S_AXI_AWPROT, S_AXI_ARPROT;
  logic            S_AXI_AWVALID, S_AXI_AWREADY;
  logic [DW-1:0]   S_AXI_WDATA;
  logic [DW/8-1:0] S_AXI_WSTRB;
  logic            S_AXI_WVALID, S_AXI_WREADY;
  logic [1:0]      S_AXI_BRESP;
  logic            S_AXI_BVALID, S_AXI_BREADY;
  logic            S_AXI_ARVALID, S_AXI_ARREADY;
  logic [DW-1:0]   S_AXI_RDATA;
  logic [1:0]      S_AXI_RRESP;
  logic            S_AXI_RVALID, S_AXI_RREADY;
  logic [NR*DW-1:0] reg_out, reg_in;
  logic [NR-1:0]   wr_pulse;
`ifdef DESIP_AXIL_IRQ_EN
  logic            irq_event, irq;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 ACLK = ~ACLK;

  desip_axil_regbank dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .reg_out(reg_out), .reg_in(reg_in), .wr_pulse(wr_pulse)
`ifdef DESIP_AXIL_IRQ_EN
    , .irq_event(irq_event), .irq(irq)
`endif
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Entered and left at #1 after a rising edge; records every wr_pulse seen until B completes
  task automatic applyWrite(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [3:0] strb,
                            input bit doAw, input bit doW, output logic [1:0] resp,
                            output logic [NR-1:0] pulses, output int pulseCycles);
    bit done = 0;
    resp = 2'b11;
    pulses = '0;
    pulseCycles = 0;
    S_AXI_AWADDR = addr;
    S_AXI_WDATA = data;
    S_AXI_WSTRB = strb;
    S_AXI_AWVALID = doAw;
    S_AXI_WVALID = doW;
    S_AXI_BREADY = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      bit awAcc, wAcc;
      if (wr_pulse != '0) begin
        pulses |= wr_pulse;
        pulseCycles++;
      end
      awAcc = S_AXI_AWVALID && S_AXI_AWREADY;
      wAcc = S_AXI_WVALID && S_AXI_WREADY;
      if (S_AXI_BVALID) begin
        resp = S_AXI_BRESP;
        done = 1;
      end
      @(posedge ACLK); #1;
      if (awAcc) S_AXI_AWVALID = 1'b0;
      if (wAcc) S_AXI_WVALID = 1'b0;
    end
    if (!done) checkOutput("wr_timeout", 0, 1);
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID = 1'b0;
  endtask

  task automatic applyRead(input logic [AW-1:0] addr, output logic [DW-1:0] data, output logic [1:0] resp);
    bit done = 0;
    data = '1;
    resp = 2'b11;
    S_AXI_ARADDR = addr;
    S_AXI_ARVALID = 1'b1;
    S_AXI_RREADY = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      bit arAcc;
      arAcc = S_AXI_ARVALID && S_AXI_ARREADY;
      if (S_AXI_RVALID) begin
        data = S_AXI_RDATA;
        resp = S_AXI_RRESP;
        done = 1;
      end
      @(posedge ACLK); #1;
      if (arAcc) S_AXI_ARVALID = 1'b0;
    end
    if (!done) checkOutput("rd_timeout", 0, 1);
    S_AXI_ARVALID = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0]    resp;
    logic [NR-1:0] pulses;
    int            pc;
    logic [DW-1:0] rdata;

    ARESETN = 1'b0;
    S_AXI_AWADDR = '0; S_AXI_ARADDR = '0; S_AXI_AWPROT = '0; S_AXI_ARPROT = '0;
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_BREADY = 1; S_AXI_RREADY = 1;
    reg_in = '0;
    reg_in[7*DW +: DW] = 32'hDEADBEEF;
`ifdef DESIP_AXIL_IRQ_EN
    irq_event = 0;
`endif

    repeat (3) @(posedge ACLK);
    #1;
    checkOutput("rst_awready", S_AXI_AWREADY, 0);
    checkOutput("rst_arready", S_AXI_ARREADY, 0);
    checkOutput("rst_bvalid", S_AXI_BVALID, 0);
    checkOutput("rst_rvalid", S_AXI_RVALID, 0);
    checkOutput("rst_reg_out", reg_out, 0);
    checkOutput("rst_wr_pulse", wr_pulse, 0);
    ARESETN = 1'b1;
    checkOutput("release_awready_low", S_AXI_AWREADY, 0);
    @(posedge ACLK); #1;
    checkOutput("release_awready", S_AXI_AWREADY, 1);
    checkOutput("release_wready", S_AXI_WREADY, 1);
    checkOutput("release_arready", S_AXI_ARREADY, 1);

    for (int i = 0; i < 4; i++) begin
      applyWrite(AW'(i*4), DW'(i+1), 4'hF, 1, 1, resp, pulses, pc);
      checkOutput($sformatf("wr%0d_resp", i), resp, 2'b00);
      checkOutput($sformatf("wr%0d_pulse", i), pulses, NR'(1) << i);
      checkOutput($sformatf("wr%0d_pulse_len", i), pc, 1);
    end
    for (int i = 0; i < 4; i++) begin
      applyRead(AW'(i*4), rdata, resp);
      checkOutput($sformatf("rd%0d_data", i), rdata, DW'(i+1));
      checkOutput($sformatf("rd%0d_resp", i), resp, 2'b00);
    end
    checkOutput("reg_out_slice3", reg_out[3*DW +: DW], 32'd4);

    S_AXI_WDATA = 32'hA5A5A5A5;
    S_AXI_WSTRB = 4'hF;
    S_AXI_WVALID = 1'b1;
    checkOutput("w_early_ready", S_AXI_WREADY, 1);
    @(posedge ACLK); #1;
    S_AXI_WVALID = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checkOutput("w_early_no_pulse", wr_pulse, 0);
      checkOutput("w_early_wready_low", S_AXI_WREADY, 0);
      @(posedge ACLK); #1;
    end
    checkOutput("w_early_reg1_kept", reg_out[1*DW +: DW], 32'd2);
    applyWrite(6'h04, 32'h0, 4'h0, 1, 0, resp, pulses, pc);
    checkOutput("w_early_resp", resp, 2'b00);
    checkOutput("w_early_pulse", pulses, 8'h02);
    checkOutput("w_early_reg1", reg_out[1*DW +: DW], 32'hA5A5A5A5);
    applyWrite(6'h04, 32'h000000FF, 4'h1, 1, 1, resp, pulses, pc);
    applyRead(6'h04, rdata, resp);
    checkOutput("strb_rd_data", rdata, 32'hA5A5A5FF);

    applyWrite(6'h00, 32'hFFFFFFFF, 4'h0, 1, 1, resp, pulses, pc);
    checkOutput("strb0_pulse", pulses, 8'h01);
    checkOutput("strb0_resp", resp, 2'b00);
    applyRead(6'h00, rdata, resp);
    checkOutput("strb0_kept", rdata, 32'd1);

    applyWrite(6'h1C, 32'h12345678, 4'hF, 1, 1, resp, pulses, pc);
    checkOutput("ro_wr_resp", resp, 2'b10);
    checkOutput("ro_wr_pulse", pulses, 0);
    applyRead(6'h1C, rdata, resp);
    checkOutput("ro_rd_data", rdata, 32'hDEADBEEF);
    checkOutput("ro_rd_resp", resp, 2'b00);
    checkOutput("ro_reg_out", reg_out[7*DW +: DW], 0);

    applyWrite(6'h38, 32'h11111111, 4'hF, 1, 1, resp, pulses, pc);
    checkOutput("oor_wr_resp", resp, 2'b10);
    checkOutput("oor_wr_pulse", pulses, 0);
    applyRead(6'h38, rdata, resp);
    checkOutput("oor_rd_data", rdata, 0);
    checkOutput("oor_rd_resp", resp, 2'b10);
`ifndef DESIP_AXIL_IRQ_EN
    applyRead(6'h20, rdata, resp);
    checkOutput("idx8_rd_resp", resp, 2'b10);
`endif

    S_AXI_AWADDR = 6'h08;
    S_AXI_WDATA = 32'h33;
    S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID = 1'b1;
    S_AXI_BREADY = 1'b0;
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID = 1'b0;
    checkOutput("hold_commit_pulse", wr_pulse, 8'h04);
    @(posedge ACLK); #1;
    checkOutput("hold_bvalid_up", S_AXI_BVALID, 1);
    checkOutput("hold_reg2", reg_out[2*DW +: DW], 32'h33);
    S_AXI_AWADDR = 6'h0C;
    S_AXI_WDATA = 32'h44;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID = 1'b1;
    checkOutput("hold_aw_buffer_ready", S_AXI_AWREADY, 1);
    @(posedge ACLK); #1;
    for (int k = 0; k < 8; k++) begin
      checkOutput("hold_bvalid", S_AXI_BVALID, 1);
      checkOutput("hold_bresp", S_AXI_BRESP, 2'b00);
      checkOutput("hold_aw_stall", S_AXI_AWREADY, 0);
      checkOutput("hold_w_stall", S_AXI_WREADY, 0);
      checkOutput("hold_no_pulse", wr_pulse, 0);
      @(posedge ACLK); #1;
    end
    ARESETN = 1'b0;
    @(posedge ACLK); #1;
    checkOutput("midrst_bvalid", S_AXI_BVALID, 0);
    checkOutput("midrst_bresp", S_AXI_BRESP, 0);
    checkOutput("midrst_awready", S_AXI_AWREADY, 0);
    checkOutput("midrst_wready", S_AXI_WREADY, 0);
    checkOutput("midrst_arready", S_AXI_ARREADY, 0);
    checkOutput("midrst_rdata", S_AXI_RDATA, 0);
    checkOutput("midrst_reg_out", reg_out, 0);
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b1;
    ARESETN = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;
    for (int k = 0; k < 3; k++) begin
      checkOutput("postrst_no_pulse", wr_pulse, 0);
      checkOutput("postrst_no_bvalid", S_AXI_BVALID, 0);
      @(posedge ACLK); #1;
    end
    applyRead(6'h0C, rdata, resp);
    checkOutput("postrst_reg3", rdata, 0);

`ifdef DESIP_AXIL_IRQ_EN
    applyWrite(6'h24, 32'h1, 4'h1, 1, 1, resp, pulses, pc);
    checkOutput("irq_en_resp", resp, 2'b00);
    checkOutput("irq_en_no_pulse", pulses, 0);
    irq_event = 1'b1;
    @(posedge ACLK); #1;
    irq_event = 1'b0;
    checkOutput("irq_lat_low", irq, 0);
    @(posedge ACLK); #1;
    checkOutput("irq_high", irq, 1);
    applyRead(6'h20, rdata, resp);
    checkOutput("irq_status_rd", rdata, 1);
    applyWrite(6'h20, 32'h1, 4'h1, 1, 1, resp, pulses, pc);
    checkOutput("irq_clr_resp", resp, 2'b00);
    checkOutput("irq_cleared", irq, 0);
    applyRead(6'h20, rdata, resp);
    checkOutput("irq_status_clr", rdata, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
